// File: rtl/alu_control_stage_if.sv
// Request/response bundle between the decoder, the ALU control stage and the ALU.
// The stage itself attaches through the slave modport.
interface alu_control_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
);
    logic                  valid_i;
    logic                  ready_o;
    logic [1:0]            ALUOp_i;
    logic [2:0]            funct3_i;
    logic [6:0]            funct7_i;
    logic [DATA_WIDTH-1:0] A_i;
    logic [DATA_WIDTH-1:0] B_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [3:0]            ALU_Operation_o;
    logic [DATA_WIDTH-1:0] A_o;
    logic [DATA_WIDTH-1:0] B_o;
    logic                  illegal_o;
    logic [CNT_WIDTH-1:0]  illegal_count_o;

    modport slave (
        input  valid_i, ALUOp_i, funct3_i, funct7_i, A_i, B_i, ready_i,
        output ready_o, valid_o, ALU_Operation_o, A_o, B_o,
        output illegal_o, illegal_count_o
    );

    modport master (
        output valid_i, ALUOp_i, funct3_i, funct7_i, A_i, B_i, ready_i,
        input  ready_o, valid_o, ALU_Operation_o, A_o, B_o,
        input  illegal_o, illegal_count_o
    );
endinterface

// File: rtl/alu_control_stage.sv
// ALU control stage: decodes ALUOp/funct3/funct7 into the ALU op code and
// carries the operands through an output register plus one skid entry.
module alu_control_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input logic                clk,
    input logic                reset,
    alu_control_stage_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0011;

    typedef struct packed {
        logic [3:0]            op;
        logic                  ill;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } beat_t;

    logic                 or_valid;
    logic                 sk_valid;
    beat_t                or_beat;
    beat_t                sk_beat;
    beat_t                in_beat;
    logic [CNT_WIDTH-1:0] cnt;
    logic [3:0]           dec_op;
    logic                 dec_ill;
    logic                 accept;
    logic                 xfer;
    logic                 or_free;
    logic                 r_add;
    logic                 r_sub;
    logic                 r_or;

    assign r_add = bus.funct3_i == 3'b000 && bus.funct7_i == 7'b0000000;
    assign r_sub = bus.funct3_i == 3'b000 && bus.funct7_i == 7'b0100000;
    assign r_or  = bus.funct3_i == 3'b110 && bus.funct7_i == 7'b0000000;

    always_comb begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
        unique case (bus.ALUOp_i)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                unique case (1'b1)
                    r_add:   dec_op = OP_ADD;
                    r_sub:   dec_op = OP_SUB;
                    r_or:    dec_op = OP_OR;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: begin
                // funct7 carries immediate bits for I-type, so it is ignored
                unique case (bus.funct3_i)
                    3'b000:  dec_op = OP_ADD;
                    3'b110:  dec_op = OP_OR;
                    default: dec_ill = 1'b1;
                endcase
            end
        endcase
    end

    always_comb begin
        in_beat     = '0;
        in_beat.op  = dec_op;
        in_beat.ill = dec_ill;
        in_beat.a   = bus.A_i;
        in_beat.b   = bus.B_i;
    end

    assign accept  = bus.valid_i & ~sk_valid;
    assign xfer    = or_valid & bus.ready_i;
    assign or_free = ~or_valid | xfer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
            or_beat  <= '0;
            sk_beat  <= '0;
        end else if (or_free) begin
            if (sk_valid) begin
                or_valid <= 1'b1;
                or_beat  <= sk_beat;
                sk_valid <= accept;
                if (accept) sk_beat <= in_beat;
            end else begin
                or_valid <= accept;
                if (accept) or_beat <= in_beat;
            end
        end else if (accept) begin
            sk_valid <= 1'b1;
            sk_beat  <= in_beat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept && dec_ill && cnt != '1) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    assign bus.ready_o         = ~sk_valid;
    assign bus.valid_o         = or_valid;
    assign bus.ALU_Operation_o = or_beat.op;
    assign bus.A_o             = or_beat.a;
    assign bus.B_o             = or_beat.b;
    assign bus.illegal_o       = or_beat.ill;
    assign bus.illegal_count_o = cnt;
endmodule

// File: tb/tb_alu_control_stage.sv
// Directed bench for alu_control_stage: decode table, backpressure,
// throughput, reset mid-stream and illegal counter saturation.
module tb_alu_control_stage;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   exp_cnt;

    alu_control_stage_if #(.DATA_WIDTH(32), .CNT_WIDTH(8)) bus ();

    alu_control_stage #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        ill;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        bus.valid_i  = v;
        bus.ALUOp_i  = op;
        bus.funct3_i = f3;
        bus.funct7_i = f7;
        bus.A_i      = a;
        bus.B_i      = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;
        vecs[0]  = '{2'b00, 3'b101, 7'b1111111, 32'h1234_5678, 32'h1, 4'b0000, 1'b0};
        vecs[1]  = '{2'b01, 3'b010, 7'b0000000, 32'h0000_0010, 32'h2, 4'b0001, 1'b0};
        vecs[2]  = '{2'b10, 3'b000, 7'b0000000, 32'h0000_0020, 32'h3, 4'b0000, 1'b0};
        vecs[3]  = '{2'b10, 3'b000, 7'b0100000, 32'h0000_0030, 32'h4, 4'b0001, 1'b0};
        vecs[4]  = '{2'b10, 3'b110, 7'b0000000, 32'h0000_0040, 32'h5, 4'b0011, 1'b0};
        vecs[5]  = '{2'b11, 3'b000, 7'b0100000, 32'h0000_0050, 32'h6, 4'b0000, 1'b0};
        vecs[6]  = '{2'b11, 3'b110, 7'b1010101, 32'h0000_0060, 32'h7, 4'b0011, 1'b0};
        vecs[7]  = '{2'b10, 3'b111, 7'b0000000, 32'h0000_0070, 32'h8, 4'b0000, 1'b1};
        vecs[8]  = '{2'b11, 3'b001, 7'b0000000, 32'h0000_0080, 32'h9, 4'b0000, 1'b1};
        vecs[9]  = '{2'b10, 3'b110, 7'b0100000, 32'h0000_0090, 32'ha, 4'b0000, 1'b1};
        vecs[10] = '{2'b11, 3'b111, 7'b0000000, 32'h0000_00a0, 32'hb, 4'b0000, 1'b1};
        vecs[11] = '{2'b10, 3'b001, 7'b0000000, 32'h0000_00b0, 32'hc, 4'b0000, 1'b1};
        vecs[12] = '{2'b10, 3'b000, 7'b0000001, 32'h0000_00c0, 32'hd, 4'b0000, 1'b1};

        reset       = 1'b0;
        bus.ready_i = 1'b1;
        drive(1'b0, 2'b00, 3'b000, 7'b0, 32'h0, 32'h0);
        #12;
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        check("rst_ready", 64'(bus.ready_o), 64'd1);
        check("rst_op", 64'(bus.ALU_Operation_o), 64'd0);
        check("rst_a", 64'(bus.A_o), 64'd0);
        check("rst_b", 64'(bus.B_o), 64'd0);
        check("rst_ill", 64'(bus.illegal_o), 64'd0);
        check("rst_cnt", 64'(bus.illegal_count_o), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // decode sweep, one beat per cycle
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vecs[i].aluop, vecs[i].f3, vecs[i].f7,
                  vecs[i].a, vecs[i].b);
            tick();
            if (vecs[i].ill) exp_cnt++;
            check($sformatf("dec%0d_valid", i), 64'(bus.valid_o), 64'd1);
            check($sformatf("dec%0d_op", i), 64'(bus.ALU_Operation_o),
                  64'(vecs[i].op));
            check($sformatf("dec%0d_ill", i), 64'(bus.illegal_o),
                  64'(vecs[i].ill));
            check($sformatf("dec%0d_a", i), 64'(bus.A_o), 64'(vecs[i].a));
            check($sformatf("dec%0d_b", i), 64'(bus.B_o), 64'(vecs[i].b));
            check($sformatf("dec%0d_cnt", i), 64'(bus.illegal_count_o),
                  64'(exp_cnt));
        end
        drive(1'b0, 2'b00, 3'b000, 7'b0, 32'h0, 32'h0);
        tick();
        check("idle_valid", 64'(bus.valid_o), 64'd0);

        // backpressure: beat3 is illegal and must not count while stalled
        bus.ready_i = 1'b0;
        drive(1'b1, 2'b01, 3'b000, 7'b0, 32'hb001, 32'h1);
        tick();
        check("bp1_valid", 64'(bus.valid_o), 64'd1);
        check("bp1_a", 64'(bus.A_o), 64'hb001);
        check("bp1_ready", 64'(bus.ready_o), 64'd1);
        drive(1'b1, 2'b11, 3'b110, 7'b0, 32'hb002, 32'h2);
        tick();
        check("bp2_ready", 64'(bus.ready_o), 64'd0);
        check("bp2_a_hold", 64'(bus.A_o), 64'hb001);
        check("bp2_op_hold", 64'(bus.ALU_Operation_o), 64'd1);
        drive(1'b1, 2'b10, 3'b111, 7'b0, 32'hb003, 32'h3);
        tick();
        check("bp3_ready", 64'(bus.ready_o), 64'd0);
        check("bp3_a_hold", 64'(bus.A_o), 64'hb001);
        check("bp3_cnt", 64'(bus.illegal_count_o), 64'(exp_cnt));
        bus.ready_i = 1'b1;
        tick();
        check("bp_out2_a", 64'(bus.A_o), 64'hb002);
        check("bp_out2_op", 64'(bus.ALU_Operation_o), 64'd3);
        check("bp_out2_ready", 64'(bus.ready_o), 64'd1);
        check("bp_out2_cnt", 64'(bus.illegal_count_o), 64'(exp_cnt));
        tick();
        exp_cnt++;
        check("bp_out3_a", 64'(bus.A_o), 64'hb003);
        check("bp_out3_ill", 64'(bus.illegal_o), 64'd1);
        check("bp_out3_cnt", 64'(bus.illegal_count_o), 64'(exp_cnt));
        drive(1'b0, 2'b00, 3'b000, 7'b0, 32'h0, 32'h0);
        tick();
        check("bp_drain", 64'(bus.valid_o), 64'd0);

        // throughput: one beat per cycle, visible one cycle after accept
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'b00, 3'b000, 7'b0, 32'(i + 100), 32'(i));
            tick();
            check($sformatf("tp%0d_valid", i), 64'(bus.valid_o), 64'd1);
            check($sformatf("tp%0d_a", i), 64'(bus.A_o), 64'(i + 100));
            check($sformatf("tp%0d_ready", i), 64'(bus.ready_o), 64'd1);
        end
        drive(1'b0, 2'b00, 3'b000, 7'b0, 32'h0, 32'h0);
        tick();
        check("tp_end", 64'(bus.valid_o), 64'd0);

        // reset with beats in both registers
        bus.ready_i = 1'b0;
        drive(1'b1, 2'b10, 3'b111, 7'b0, 32'hc001, 32'h0);
        tick();
        drive(1'b1, 2'b00, 3'b000, 7'b0, 32'hc002, 32'h0);
        tick();
        check("mid_ready", 64'(bus.ready_o), 64'd0);
        check("mid_cnt", 64'(bus.illegal_count_o), 64'(exp_cnt + 1));
        drive(1'b0, 2'b00, 3'b000, 7'b0, 32'h0, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        exp_cnt = 0;
        check("mrst_valid", 64'(bus.valid_o), 64'd0);
        check("mrst_ready", 64'(bus.ready_o), 64'd1);
        check("mrst_cnt", 64'(bus.illegal_count_o), 64'd0);
        check("mrst_a", 64'(bus.A_o), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.ready_i = 1'b1;
        tick();
        check("post_idle", 64'(bus.valid_o), 64'd0);
        drive(1'b1, 2'b01, 3'b000, 7'b0, 32'hd00d, 32'h0);
        tick();
        check("post_valid", 64'(bus.valid_o), 64'd1);
        check("post_a", 64'(bus.A_o), 64'hd00d);
        check("post_op", 64'(bus.ALU_Operation_o), 64'd1);

        // saturation of the illegal counter
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 2'b11, 3'b011, 7'b0, 32'(i), 32'h0);
            tick();
            if (exp_cnt < 255) exp_cnt++;
            if (i == 10 || i == 254 || i == 299)
                check($sformatf("sat%0d_cnt", i),
                      64'(bus.illegal_count_o), 64'(exp_cnt));
        end
        drive(1'b1, 2'b10, 3'b010, 7'b0, 32'h0, 32'h0);
        tick();
        check("sat_hold", 64'(bus.illegal_count_o), 64'd255);
        check("sat_ill", 64'(bus.illegal_o), 64'd1);
        drive(1'b0, 2'b00, 3'b000, 7'b0, 32'h0, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_control_stage.md
Name: alu_control_stage

Overview:
- Registered decode stage that produces the 4-bit ALU operation code and operand pair consumed by the ALU. It is the encoder end of the ALU operation interface.
- Translates the main-decoder class (ALUOp) plus funct3/funct7 into the ALU encodings: ADD=4'b0000, SUB=4'b0001, OR=4'b0011.
- Carries the operands alongside the op through a 2-entry skid buffer with valid/ready handshakes on both sides.
- Flags and counts unsupported encodings.

Parameters:
- DATA_WIDTH, 32, width of operand A/B passthrough
- CNT_WIDTH, 8, width of saturating illegal-op counter

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- valid_i  input  1  upstream request valid
- ready_o  output  1  stage can accept request
- ALUOp_i  input  2  class: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU
- funct3_i  input  3  instruction funct3
- funct7_i  input  7  instruction funct7
- A_i  input  DATA_WIDTH  operand A
- B_i  input  DATA_WIDTH  operand B
- valid_o  output  1  output beat valid
- ready_i  input  1  downstream accepts beat
- ALU_Operation_o  output  4  encoded ALU op
- A_o  output  DATA_WIDTH  operand A, aligned with op
- B_o  output  DATA_WIDTH  operand B, aligned with op
- illegal_o  output  1  current output beat carries an unsupported encoding
- illegal_count_o  output  CNT_WIDTH  saturating count of accepted illegal requests

Behaviour:
- Reset (asynchronous, active-low):
  - valid_o=0, ready_o=1, ALU_Operation_o=4'b0000, A_o=B_o=0, illegal_o=0, illegal_count_o=0.
  - Skid entry is cleared.
  - Any beat held in the stage is discarded. No partial beat appears after release.
- Decode, combinational on inputs and captured at acceptance:
  - ALUOp 00 -> ADD, independent of funct fields.
  - ALUOp 01 -> SUB.
  - ALUOp 10, funct3 000 and funct7 0000000 -> ADD.
  - ALUOp 10, funct3 000 and funct7 0100000 -> SUB.
  - ALUOp 10, funct3 110 and funct7 0000000 -> OR.
  - ALUOp 10, any other combination -> op 4'b0000, illegal=1.
  - ALUOp 11, funct3 000 -> ADD. funct7 is ignored (immediate bits).
  - ALUOp 11, funct3 110 -> OR.
  - ALUOp 11, any other funct3 -> op 4'b0000, illegal=1.
- Handshake:
  - Accept occurs when valid_i & ready_o. Transfer out occurs when valid_o & ready_i.
  - ready_o is registered and equals ~skid_valid. It does not depend combinationally on ready_i.
  - While valid_o=1 and ready_i=0, ALU_Operation_o, A_o, B_o and illegal_o hold stable.
- Storage: one output register (OR) plus one skid register (SK).
  - OR empty or transferring this cycle, SK empty: an accepted beat loads into OR.
  - OR empty or transferring this cycle, SK full: SK moves to OR. An accepted beat, if any, loads into SK (only possible if ready_o was 1, i.e. SK was empty last cycle). Order is always preserved.
  - OR full and not transferring: an accepted beat loads into SK, and ready_o falls next cycle.
  - Simultaneous accept and transfer with SK empty: new beat goes to OR. Throughput is 1 beat/cycle.
- Latency and throughput:
  - Latency is 1 cycle: a beat accepted in cycle N is visible on the outputs in cycle N+1 if OR is free.
  - Sustained throughput is 1 beat/cycle with ready_i held high.
- Counter:
  - illegal_count_o increments by 1 on each accepted illegal beat, at accept time.
  - It saturates at 2^CNT_WIDTH-1 and never wraps.
  - It is cleared only by reset.
- Beats with valid_i=0 are ignored. Input values while not accepted have no effect.

Test Plan:
1. Reset mid-stream: beats present in OR and SK, assert reset=0 -> valid_o=0, ready_o=1 and illegal_count_o=0 immediately. After release, the first new beat appears 1 cycle after accept.
2. Decode sweep, ready_i=1: {00,xxx,x} -> 0000. {01} -> 0001. {10,000,0000000} -> 0000. {10,000,0100000} -> 0001. {10,110,0000000} -> 0011. {11,000,0100000} -> 0000, illegal_o=0. {11,110} -> 0011. A_i=32'h1234_5678 appears on A_o with its op.
3. Backpressure: 3 back-to-back beats with ready_i=0 -> beat1 in OR, beat2 in SK, ready_o=0 from cycle 3, beat3 not accepted. Raise ready_i -> beats 1, 2, 3 exit in order with no loss or duplication.
4. Throughput: 16 consecutive valid beats with ready_i=1 -> 16 output beats on 16 consecutive cycles, each 1 cycle after its accept.
5. Illegal handling: {10,111,0000000} -> op 0000, illegal_o=1, count 0->1. {11,001} -> count 2. A held-but-unaccepted illegal input (ready_o=0) does not increment the count.
6. Saturation: CNT_WIDTH=8, 300 accepted illegal beats -> illegal_count_o=255 and it stays at 255.
